// File: rtl/coef_collector_pkg.sv
// Shared definitions for the coefficient collector: state encoding and width helper.
package coef_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  // Ceiling log2; a result of 0 is bumped to 1 by callers that need a real width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/coef_lane_sipo.sv
// One coefficient lane: N-bit right-shifting SIPO, LSB arrives first.
module coef_lane_sipo #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         shift_en,
  input  logic         bit_in,
  output logic [N-1:0] shifted
);

  logic [N-1:0] sr_q;
  logic [N-1:0] sr_d;

  // Value the register takes if this cycle shifts; also used to load the output frame.
  assign shifted = {bit_in, sr_q[N-1:1]};

  always_comb begin
    sr_d = sr_q;
    if (clr) begin
      sr_d = '0;
    end else if (shift_en) begin
      sr_d = shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/coef_collector.sv
// Deserializing result collector: gathers N columns of K lane bits into K
// parallel N-bit coefficients presented on a valid/ready handshake.
//
// state   | meaning
// IDLE    | waiting for start; columns ignored
// COLLECT | shifting in columns, cnt counts accepted columns
// HOLD    | frame complete, out_valid high until out_ready
module coef_collector
  import coef_collector_pkg::*;
#(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           bit_valid,
  input  logic [K-1:0]   bit_in,
  input  logic           out_ready,
  output logic [K*N-1:0] coef_out,
  output logic           out_valid,
  output logic           busy,
  output logic           overrun
);

  localparam int CNT_W = (clog2(N) < 1) ? 1 : clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [K*N-1:0]   coef_q, coef_d;
  logic             overrun_q, overrun_d;

  logic             lane_clr;
  logic             lane_shift;
  logic [K*N-1:0]   shifted_all;

  for (genvar k = 0; k < K; k++) begin : g_lane
    coef_lane_sipo #(.N(N)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .clr     (lane_clr),
      .shift_en(lane_shift),
      .bit_in  (bit_in[k]),
      .shifted (shifted_all[k*N +: N])
    );
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    coef_d     = coef_q;
    overrun_d  = overrun_q;
    lane_clr   = 1'b0;
    lane_shift = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_COLLECT;
          lane_clr  = 1'b1;
          cnt_d     = '0;
          overrun_d = 1'b0;
        end
      end

      ST_COLLECT: begin
        // A restart discards whatever column arrives alongside it.
        if (start) begin
          lane_clr  = 1'b1;
          cnt_d     = '0;
          overrun_d = 1'b0;
        end else if (bit_valid) begin
          lane_shift = 1'b1;
          if (cnt_q == CNT_LAST) begin
            coef_d  = shifted_all;
            cnt_d   = '0;
            state_d = ST_HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_HOLD: begin
        if (bit_valid) begin
          overrun_d = 1'b1;
        end
        if (out_ready) begin
          if (start) begin
            state_d   = ST_COLLECT;
            lane_clr  = 1'b1;
            cnt_d     = '0;
            overrun_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      coef_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      coef_q    <= coef_d;
      overrun_q <= overrun_d;
    end
  end

  assign coef_out  = coef_q;
  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q == ST_COLLECT);
  assign overrun   = overrun_q;

endmodule
